eth_rx_ctrl: RTL and testbench

ETH_RX_CTRL -- requirements
Module: eth_rx_ctrl

---
 rtl/eth_rx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_eth_rx_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_ctrl.sv
// Ethernet receive controller: parses DST/SRC/EtherType from a byte stream,
// filters on destination address, and forwards the payload with length/end status.
`timescale 1ns/1ps
module eth_rx_ctrl #(
  parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int          MAX_PAYLOAD  = 1500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  input  logic        i_frame_end,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_ethertype,
  output logic        o_hdr_valid,
  input  logic        i_hdr_ready,
  output logic        o_pl_valid,
  output logic [7:0]  o_pl_data,
  output logic        o_pl_end,
  output logic        o_pl_abort,
  output logic [10:0] o_pl_len,
  output logic [15:0] o_drop_cnt,
  output logic        o_busy
);

  localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD);

  typedef enum logic [2:0] {IDLE, DST, SRC, TYPE, PAYLOAD, DISCARD} state_t;

  state_t      state, byte_state, nxt_state;
  logic [47:0] hdr_dst, hdr_src, dst_shift, src_shift;
  logic [7:0]  hdr_type;
  logic [2:0]  byte_cnt, cnt_nxt;
  logic [10:0] pl_cnt, pl_cnt_nxt;
  logic        addr_ok, hdr_load, pl_fwd, pl_abort, pl_end, drop_inc;

  // A byte arriving with i_frame_end is applied first (byte_state), then the
  // end-of-frame rules act on the state that byte produced (nxt_state).
  always_comb begin
    dst_shift  = {hdr_dst[39:0], i_byte};
    src_shift  = {hdr_src[39:0], i_byte};
    addr_ok    = (dst_shift == MAC_ADDR) || (ACCEPT_BCAST && (dst_shift == '1));
    byte_state = state;
    cnt_nxt    = byte_cnt;
    pl_cnt_nxt = pl_cnt;
    hdr_load   = 1'b0;
    pl_fwd     = 1'b0;
    pl_abort   = 1'b0;
    pl_end     = 1'b0;
    drop_inc   = 1'b0;
    if (i_byte_valid) begin
      case (state)
        IDLE: begin
          byte_state = DST;
          cnt_nxt    = 3'd1;
          pl_cnt_nxt = '0;
        end
        DST: begin
          if (byte_cnt == 3'd5) begin
            cnt_nxt    = '0;
            byte_state = addr_ok ? SRC : DISCARD;
          end else begin
            cnt_nxt = byte_cnt + 3'd1;
          end
        end
        SRC: begin
          if (byte_cnt == 3'd5) begin
            cnt_nxt    = '0;
            byte_state = TYPE;
          end else begin
            cnt_nxt = byte_cnt + 3'd1;
          end
        end
        TYPE: begin
          if (byte_cnt == 3'd1) begin
            cnt_nxt = '0;
            if (o_hdr_valid && !i_hdr_ready) begin
              byte_state = DISCARD;
              drop_inc   = 1'b1;
            end else begin
              byte_state = PAYLOAD;
              hdr_load   = 1'b1;
              pl_cnt_nxt = '0;
            end
          end else begin
            cnt_nxt = byte_cnt + 3'd1;
          end
        end
        PAYLOAD: begin
          if (pl_cnt == MAX_LEN) begin
            pl_abort   = 1'b1;
            drop_inc   = 1'b1;
            byte_state = DISCARD;
          end else begin
            pl_fwd     = 1'b1;
            pl_cnt_nxt = pl_cnt + 11'd1;
          end
        end
        default: ;
      endcase
    end
    nxt_state = byte_state;
    if (i_frame_end) begin
      case (byte_state)
        DST, SRC, TYPE: begin
          drop_inc  = 1'b1;
          nxt_state = IDLE;
        end
        PAYLOAD: begin
          pl_end    = 1'b1;
          nxt_state = IDLE;
        end
        DISCARD: nxt_state = IDLE;
        default: ;
      endcase
    end
  end

  // Header handshake: o_hdr_valid rises with a loaded header and holds the
  // header registers stable until a cycle with i_hdr_ready high; a header
  // completing in that same cycle replaces it and keeps o_hdr_valid high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      pl_cnt      <= '0;
      hdr_dst     <= '0;
      hdr_src     <= '0;
      hdr_type    <= '0;
      o_dst_mac   <= '0;
      o_src_mac   <= '0;
      o_ethertype <= '0;
      o_hdr_valid <= 1'b0;
      o_pl_valid  <= 1'b0;
      o_pl_data   <= '0;
      o_pl_end    <= 1'b0;
      o_pl_abort  <= 1'b0;
      o_pl_len    <= '0;
      o_drop_cnt  <= '0;
      o_busy      <= 1'b0;
    end else begin
      state      <= nxt_state;
      byte_cnt   <= cnt_nxt;
      pl_cnt     <= pl_cnt_nxt;
      o_busy     <= (nxt_state != IDLE);
      o_pl_valid <= pl_fwd;
      o_pl_end   <= pl_end;
      o_pl_abort <= pl_abort;
      if (pl_fwd) o_pl_data <= i_byte;
      if (pl_end) o_pl_len <= pl_cnt_nxt;
      else if (pl_abort) o_pl_len <= MAX_LEN;
      if (i_byte_valid) begin
        case (state)
          IDLE, DST: hdr_dst  <= dst_shift;
          SRC:       hdr_src  <= src_shift;
          TYPE:      hdr_type <= i_byte;
          default: ;
        endcase
      end
      if (o_hdr_valid && i_hdr_ready) o_hdr_valid <= 1'b0;
      if (hdr_load) begin
        o_dst_mac   <= hdr_dst;
        o_src_mac   <= hdr_src;
        o_ethertype <= {hdr_type, i_byte};
        o_hdr_valid <= 1'b1;
      end
      if (drop_inc && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Directed bench for eth_rx_ctrl: payload bytes and end/abort events are
// queued when driven and checked by a monitor on the falling edge.
`timescale 1ns/1ps
module tb_eth_rx_ctrl;

  localparam int          MAXP   = 8;
  localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC_A  = 48'h00_11_22_33_44_55;
  localparam logic [47:0] SRC_B  = 48'h0a_0b_0c_0d_0e_0f;

  logic        i_clk, i_rst, i_byte_valid, i_frame_end, i_hdr_ready;
  logic [7:0]  i_byte;
  logic [47:0] o_dst_mac, o_src_mac;
  logic [15:0] o_ethertype, o_drop_cnt;
  logic        o_hdr_valid, o_pl_valid, o_pl_end, o_pl_abort, o_busy;
  logic [7:0]  o_pl_data;
  logic [10:0] o_pl_len;

  eth_rx_ctrl #(.MAC_ADDR(MY_MAC), .ACCEPT_BCAST(1'b1), .MAX_PAYLOAD(MAXP)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .i_frame_end(i_frame_end), .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac),
    .o_ethertype(o_ethertype), .o_hdr_valid(o_hdr_valid), .i_hdr_ready(i_hdr_ready),
    .o_pl_valid(o_pl_valid), .o_pl_data(o_pl_data), .o_pl_end(o_pl_end),
    .o_pl_abort(o_pl_abort), .o_pl_len(o_pl_len), .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          passed = 0;
  logic [7:0]  exp_q[$];
  logic [12:0] ev_q[$];   // {end, abort, len}
  logic [7:0]  exp_b;
  logic [12:0] exp_ev;
  logic [95:0] part_hdr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_hdr_valid", 64'(o_hdr_valid), 64'd0);
    chk("rst_pl_valid",  64'(o_pl_valid),  64'd0);
    chk("rst_pl_end",    64'(o_pl_end),    64'd0);
    chk("rst_pl_abort",  64'(o_pl_abort),  64'd0);
    chk("rst_dst",       64'(o_dst_mac),   64'd0);
    chk("rst_src",       64'(o_src_mac),   64'd0);
    chk("rst_type",      64'(o_ethertype), 64'd0);
    chk("rst_pl_data",   64'(o_pl_data),   64'd0);
    chk("rst_pl_len",    64'(o_pl_len),    64'd0);
    chk("rst_drop",      64'(o_drop_cnt),  64'd0);
    chk("rst_busy",      64'(o_busy),      64'd0);
  endtask

  task automatic chk_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    chk("hdr_valid", 64'(o_hdr_valid), 64'd1);
    chk("hdr_dst",   64'(o_dst_mac),   64'(d));
    chk("hdr_src",   64'(o_src_mac),   64'(s));
    chk("hdr_type",  64'(o_ethertype), 64'(t));
  endtask

  // driver: one clock of input activity
  task automatic cyc(input logic v, input logic [7:0] b, input logic e);
    i_byte_valid = v;
    i_byte       = b;
    i_frame_end  = e;
    @(posedge i_clk);
    #1;
    i_byte_valid = 1'b0;
    i_frame_end  = 1'b0;
  endtask

  task automatic release_hdr();
    i_hdr_ready = 1'b1;
    @(posedge i_clk);
    #1 i_hdr_ready = 1'b0;
    chk("hdr_release", 64'(o_hdr_valid), 64'd0);
  endtask

  // fwd: bench expects this frame to be accepted; rdy_hdr: ready on last type byte
  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] typ, input int n_pl,
                            input bit end_on_last, input bit fwd, input bit rdy_hdr);
    logic [111:0] hdr;
    logic [7:0]   b;
    hdr = {dst, src, typ};
    for (int i = 0; i < 14; i++) begin
      if (i == 13) i_hdr_ready = rdy_hdr;
      cyc(1'b1, hdr[111-8*i -: 8], 1'b0);
      i_hdr_ready = 1'b0;
    end
    if (fwd) ev_q.push_back((n_pl > MAXP) ? {2'b01, 11'(MAXP)} : {2'b10, 11'(n_pl)});
    for (int i = 0; i < n_pl; i++) begin
      b = 8'($urandom_range(0, 255));
      if (fwd && i < MAXP) exp_q.push_back(b);
      cyc(1'b1, b, end_on_last && (i == n_pl - 1));
    end
    if (!(end_on_last && n_pl > 0)) cyc(1'b0, 8'h00, 1'b1);
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    if (o_pl_valid) begin
      if (exp_q.size() == 0) chk("pl_unexpected", 64'(o_pl_valid), 64'd0);
      else begin
        exp_b = exp_q.pop_front();
        chk("pl_data", 64'(o_pl_data), 64'(exp_b));
      end
    end
    if (o_pl_end || o_pl_abort) begin
      if (ev_q.size() == 0) chk("ev_unexpected", 64'({o_pl_end, o_pl_abort}), 64'd0);
      else begin
        exp_ev = ev_q.pop_front();
        chk("pl_event", 64'({o_pl_end, o_pl_abort, o_pl_len}), 64'(exp_ev));
      end
    end
  end

  initial begin
    i_rst = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00; i_frame_end = 1'b0; i_hdr_ready = 1'b0;
    do_reset();
    chk_reset();

    // unicast frame, 4 payload bytes
    send_frame(MY_MAC, SRC_A, 16'h0800, 4, 1'b0, 1'b1, 1'b0);
    chk_hdr(MY_MAC, SRC_A, 16'h0800);
    chk("uni_drop", 64'(o_drop_cnt), 64'd0);
    chk("uni_busy", 64'(o_busy), 64'd0);
    release_hdr();

    // foreign unicast filtered silently, then broadcast accepted
    send_frame(48'h02_00_00_00_00_02, SRC_B, 16'h0800, 3, 1'b0, 1'b0, 1'b0);
    chk("filt_hdr_valid", 64'(o_hdr_valid), 64'd0);
    chk("filt_drop", 64'(o_drop_cnt), 64'd0);
    send_frame(48'hFF_FF_FF_FF_FF_FF, SRC_B, 16'h0806, 2, 1'b1, 1'b1, 1'b0);
    chk_hdr(48'hFF_FF_FF_FF_FF_FF, SRC_B, 16'h0806);
    release_hdr();

    // zero-length payload
    send_frame(MY_MAC, SRC_A, 16'h88B5, 0, 1'b0, 1'b1, 1'b0);
    chk_hdr(MY_MAC, SRC_A, 16'h88B5);
    release_hdr();

    // consumer stalled: second header dropped, first held
    do_reset();
    send_frame(MY_MAC, SRC_A, 16'h0800, 1, 1'b0, 1'b1, 1'b0);
    send_frame(MY_MAC, SRC_B, 16'h86DD, 3, 1'b0, 1'b0, 1'b0);
    chk("stall_drop", 64'(o_drop_cnt), 64'd1);
    chk_hdr(MY_MAC, SRC_A, 16'h0800);
    // ready coincident with header completion: new header accepted
    send_frame(MY_MAC, SRC_B, 16'h86DD, 2, 1'b0, 1'b1, 1'b1);
    chk_hdr(MY_MAC, SRC_B, 16'h86DD);
    chk("same_cycle_drop", 64'(o_drop_cnt), 64'd1);
    release_hdr();

    // oversize payload: truncated at MAXP bytes
    do_reset();
    send_frame(MY_MAC, SRC_A, 16'h0800, 10, 1'b0, 1'b1, 1'b0);
    chk("oversize_drop", 64'(o_drop_cnt), 64'd1);
    release_hdr();

    // runt: frame end after 9 header bytes
    do_reset();
    part_hdr = {MY_MAC, SRC_A};
    for (int i = 0; i < 9; i++) cyc(1'b1, part_hdr[95-8*i -: 8], 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("runt_drop", 64'(o_drop_cnt), 64'd1);
    chk("runt_busy", 64'(o_busy), 64'd0);
    chk("runt_hdr_valid", 64'(o_hdr_valid), 64'd0);
    // last payload byte coincident with frame end
    send_frame(MY_MAC, SRC_B, 16'h0800, 3, 1'b1, 1'b1, 1'b0);
    chk("coinc_drop", 64'(o_drop_cnt), 64'd1);
    release_hdr();

    // reset during SRC, then a clean frame
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, part_hdr[95-8*i -: 8], 1'b0);
    chk("mid_busy", 64'(o_busy), 64'd1);
    do_reset();
    chk_reset();
    send_frame(MY_MAC, SRC_A, 16'h0800, 4, 1'b0, 1'b1, 1'b0);
    chk_hdr(MY_MAC, SRC_A, 16'h0800);
    chk("post_rst_drop", 64'(o_drop_cnt), 64'd0);

    // frame end while idle is ignored
    cyc(1'b0, 8'h00, 1'b1);
    chk("idle_end_busy", 64'(o_busy), 64'd0);
    chk("idle_end_drop", 64'(o_drop_cnt), 64'd0);

    repeat (3) @(posedge i_clk);
    #1;
    chk("exp_q_drain", 64'(exp_q.size()), 64'd0);
    chk("ev_q_drain", 64'(ev_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
